multi_operand_sum_using_fifos: RTL



---
 rtl/multi_operand_sum_pkg.sv | 9 +
 rtl/multi_operand_sum_using_fifos_vr_fifo.sv | 40 ++++
 rtl/multi_operand_sum_using_fifos.sv | 63 ++++++
 3 files changed

// File: rtl/multi_operand_sum_pkg.sv
// multi_operand_sum_pkg: shared sizing helpers for the multi-operand sum block
package multi_operand_sum_pkg;
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
  function automatic int sum_width(input int width, input int n_ops);
    return width + clog2_min1(n_ops);
  endfunction
endpackage

// File: rtl/multi_operand_sum_using_fifos_vr_fifo.sv
// vr_fifo: valid/ready FIFO of any depth >= 2 with combinational head read
module vr_fifo
  import multi_operand_sum_pkg::*;
#(
  parameter int width = 8,
  parameter int depth = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [width-1:0] up_data,
  output logic             down_valid,
  input  logic             down_ready,
  output logic [width-1:0] down_data
);
  localparam int aw = clog2_min1(depth);
  logic [width-1:0] mem [depth];
  logic [aw-1:0] wr_ptr, rd_ptr;
  logic [aw:0] cnt;
  logic push, pop;
  assign up_ready = !rst && cnt != (aw+1)'(depth);
  assign down_valid = cnt != '0;
  // empty head reads as zero so outputs are defined without resetting storage
  assign down_data = down_valid ? mem[rd_ptr] : '0;
  assign push = up_valid && up_ready;
  assign pop = down_valid && down_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == aw'(depth - 1)) ? '0 : wr_ptr + aw'(1);
      if (pop) rd_ptr <= (rd_ptr == aw'(depth - 1)) ? '0 : rd_ptr + aw'(1);
      cnt <= cnt + (aw+1)'(push) - (aw+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= up_data;
endmodule

// File: rtl/multi_operand_sum_using_fifos.sv
// multi_operand_sum_using_fifos: joins n_ops buffered operand streams into a summed result stream
module multi_operand_sum_using_fifos
  import multi_operand_sum_pkg::*;
#(
  parameter int width = 8,
  parameter int depth = 10,
  parameter int n_ops = 3,
  parameter int saturate = 0,
  parameter int cnt_width = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [n_ops-1:0]       in_valid,
  output logic [n_ops-1:0]       in_ready,
  input  logic [n_ops*width-1:0] in_data,
  output logic                   sum_valid,
  input  logic                   sum_ready,
  output logic [width-1:0]       sum_data,
  output logic                   sum_ovf,
  output logic [cnt_width-1:0]   result_count
);
  localparam int sw = sum_width(width, n_ops);
  logic [n_ops-1:0] op_valid;
  logic [width-1:0] op [n_ops];
  logic fire, out_ready, ovf;
  logic [sw-1:0] full_sum;
  logic [width-1:0] res;
  logic [width:0] out_word;
  for (genvar i = 0; i < n_ops; i++) begin : g_in
    vr_fifo #(.width(width), .depth(depth)) u_fifo (
      .clk(clk),
      .rst(rst),
      .up_valid(in_valid[i]),
      .up_ready(in_ready[i]),
      .up_data(in_data[i*width +: width]),
      .down_valid(op_valid[i]),
      .down_ready(fire),
      .down_data(op[i])
    );
  end
  // every channel pops on the same fire, so operands stay aligned
  assign fire = &op_valid && out_ready;
  always_comb begin
    full_sum = '0;
    for (int i = 0; i < n_ops; i++) full_sum = full_sum + sw'(op[i]);
  end
  assign ovf = |full_sum[sw-1:width];
  assign res = (saturate != 0 && ovf) ? '1 : full_sum[width-1:0];
  vr_fifo #(.width(width + 1), .depth(depth)) u_out (
    .clk(clk),
    .rst(rst),
    .up_valid(fire),
    .up_ready(out_ready),
    .up_data({ovf, res}),
    .down_valid(sum_valid),
    .down_ready(sum_ready),
    .down_data(out_word)
  );
  assign {sum_ovf, sum_data} = out_word;
  always_ff @(posedge clk or posedge rst)
    if (rst) result_count <= '0;
    else if (fire) result_count <= result_count + cnt_width'(1);
endmodule
